// File: rtl/hexscan.sv
// hexscan: time-multiplexed seven-segment scanner with per-slot guard phase and 16-step PWM brightness
module hexdisp (
  input  logic [4:0] val,
  output logic [7:0] seg
);
  logic [6:0] g;
  always_comb begin
    case (val[3:0])
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
  end
  assign seg = {~val[4], g};
endmodule

module hexscan #(
  parameter int DIGITS = 6,
  parameter int PHASE  = 3125
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [2:0]        addr_i,
  input  logic [5:0]        data_i,
  input  logic [3:0]        bright_i,
  output logic [7:0]        seg_o,
  output logic [DIGITS-1:0] an_o,
  output logic              frame_o
);
  localparam int PW = PHASE > 1 ? $clog2(PHASE) : 1;
  logic [PW-1:0] pcnt;
  logic [3:0]    phase, blat;
  logic [2:0]    digit;
  logic [5:0]    regs [8];
  logic [7:0]    dec, sel;
  logic          pend, send, fend, on;
  assign pend = pcnt == PW'(PHASE - 1);
  assign send = pend && phase == 4'hF;
  assign fend = send && digit == 3'(DIGITS - 1);
  // phase 0 is the guard phase, so it never lights regardless of blat
  assign on   = phase != 4'h0 && phase <= blat && !regs[digit][5];
  assign sel  = 8'b1 << digit;
  hexdisp u_dec (.val(regs[digit][4:0]), .seg(dec));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcnt    <= '0;
      phase   <= '0;
      digit   <= '0;
      blat    <= '0;
      seg_o   <= 8'hFF;
      an_o    <= '1;
      frame_o <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= 6'h20;
    end else begin
      pcnt <= pend ? '0 : pcnt + 1'b1;
      if (pend) phase <= phase + 1'b1;
      if (send) digit <= fend ? 3'd0 : digit + 1'b1;
      if (phase == 4'h0 && pcnt == '0) blat <= bright_i;
      if (wr_i && {1'b0, addr_i} < 4'(DIGITS)) regs[addr_i] <= data_i;
      seg_o   <= on ? dec : 8'hFF;
      an_o    <= on ? ~sel[DIGITS-1:0] : '1;
      frame_o <= fend;
    end
  end
endmodule

// File: tb/tb_hexscan.sv
// tb_hexscan: cycle-index reference model plus decode table and multi-cycle corner sequences
module tb_hexscan;
  localparam int D = 4;
  localparam int P = 2;
  localparam int SLOT = 16 * P;
  localparam int FRAME = D * SLOT;
  logic       clk = 0, rst = 0, wr = 0;
  logic [2:0] addr = 0;
  logic [5:0] data = 0;
  logic [3:0] bright = 0;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame;
  hexscan #(.DIGITS(D), .PHASE(P)) dut (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .addr_i(addr), .data_i(data),
    .bright_i(bright), .seg_o(seg), .an_o(an), .frame_o(frame)
  );
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  int s, mblat;
  logic [5:0] mregs [D];
  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  typedef struct {logic [2:0] addr; logic [5:0] data; logic [3:0] an; logic [7:0] seg;} vec_t;
  vec_t vt [6] = '{'{3'd0, 6'h03, 4'b1110, 8'hB0}, '{3'd1, 6'h1A, 4'b1101, 8'h08},
                   '{3'd2, 6'h0C, 4'b1011, 8'hC6}, '{3'd3, 6'h15, 4'b0111, 8'h12},
                   '{3'd2, 6'h1D, 4'b1011, 8'h21}, '{3'd3, 6'h07, 4'b0111, 8'hF8}};

  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset;
    s = 0;
    mblat = 0;
    foreach (mregs[i]) mregs[i] = 6'h20;
  endtask

  // outputs after an edge reflect the state index s the edge saw
  task automatic step;
    int d, ph;
    logic on, ef;
    logic [3:0] ea;
    logic [7:0] es;
    @(posedge clk);
    d  = (s / SLOT) % D;
    ph = (s % SLOT) / P;
    on = ph != 0 && ph <= mblat && !mregs[d][5];
    ea = on ? ~(4'b0001 << d) : 4'hF;
    es = on ? (hex_tbl[mregs[d][3:0]] & (mregs[d][4] ? 8'h7F : 8'hFF)) : 8'hFF;
    ef = (s % FRAME) == FRAME - 1;
    if (s % SLOT == 0) mblat = int'(bright);
    if (wr && addr < D) mregs[addr] = data;
    s++;
    #1;
    chk("an", int'(an), int'(ea));
    chk("seg", int'(seg), int'(es));
    chk("frame", int'(frame), int'(ef));
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [5:0] d);
    addr = a;
    data = d;
    wr = 1;
    step();
    wr = 0;
  endtask

  task automatic align(input int m);
    while (s % FRAME != m) step();
  endtask

  initial begin
    int cnt, cnt1, cnt3, first, n;
    logic [7:0] last;
    #2 rst = 1;
    #1;
    chk("rst_an_async", int'(an), 4'hF);
    chk("rst_seg_async", int'(seg), 8'hFF);
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_an", int'(an), 4'hF);
      chk("rst_seg", int'(seg), 8'hFF);
      chk("rst_frame", int'(frame), 0);
    end
    rst = 0;
    bright = 15;
    model_reset();
    cnt = 0;
    first = -1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step();
      if (an != 4'hF) cnt++;
      if (frame && first < 0) first = k;
    end
    chk("blank_dark", cnt, 0);
    chk("first_frame", first, FRAME);

    for (int v = 0; v < 6; v++) begin
      wr_reg(vt[v].addr, vt[v].data);
      cnt = 0;
      last = 0;
      repeat (FRAME) begin
        step();
        if (an == vt[v].an) begin cnt++; last = seg; end
      end
      chk("on_cycles", cnt, 30);
      chk("decode", int'(last), int'(vt[v].seg));
    end

    bright = 4;
    wr_reg(0, 6'h08);
    repeat (FRAME) step();
    align(0);
    cnt = 0;
    first = -1;
    last = 0;
    for (int k = 0; k < SLOT; k++) begin
      step();
      if (an == 4'b1110) begin
        cnt++;
        last = seg;
        if (first < 0) first = k;
      end
    end
    chk("bright4_cycles", cnt, 8);
    chk("bright4_start", first, 2);
    chk("bright4_seg", int'(last), 8'h80);
    bright = 0;
    repeat (2 * FRAME) step();
    cnt = 0;
    repeat (FRAME) begin step(); if (an != 4'hF) cnt++; end
    chk("bright0_dark", cnt, 0);
    bright = 4;
    repeat (FRAME) step();
    align(0);
    cnt = 0;
    repeat (20) begin step(); if (an == 4'b1110) cnt++; end
    bright = 15;
    repeat (SLOT - 20) begin step(); if (an == 4'b1110) cnt++; end
    chk("midslot_keep", cnt, 8);
    repeat (FRAME - SLOT) step();
    cnt = 0;
    repeat (SLOT) begin step(); if (an == 4'b1110) cnt++; end
    chk("midslot_next", cnt, 30);

    wr_reg(2, 6'h25);
    wr_reg(5, 6'h00);
    cnt = 0; cnt1 = 0; cnt3 = 0; n = 0;
    repeat (FRAME) begin
      step();
      if (!an[2]) cnt++;
      if (an == 4'b1110) n++;
      if (an == 4'b1101) cnt1++;
      if (an == 4'b0111) cnt3++;
    end
    chk("blank_digit2", cnt, 0);
    chk("digit0_kept", n, 30);
    chk("digit1_kept", cnt1, 30);
    chk("digit3_kept", cnt3, 30);

    n = 0;
    while (an != 4'b1110 && n < 3 * FRAME) begin step(); n++; end
    chk("find_on", int'(an), 4'b1110);
    rst = 1;
    #1;
    chk("midrst_an", int'(an), 4'hF);
    chk("midrst_seg", int'(seg), 8'hFF);
    chk("midrst_frame", int'(frame), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
    cnt = 0;
    repeat (2 * FRAME) begin step(); if (an != 4'hF) cnt++; end
    chk("post_rst_dark", cnt, 0);

    wr_reg(0, 6'h03);
    repeat (FRAME) step();
    align(10);
    addr = 0;
    data = 6'h0F;
    wr = 1;
    step();
    wr = 0;
    chk("live_old_seg", int'(seg), 8'hB0);
    chk("live_old_an", int'(an), 4'b1110);
    step();
    chk("live_new_seg", int'(seg), 8'h8E);
    chk("live_new_an", int'(an), 4'b1110);

    repeat (1500) begin
      wr = 1'($urandom_range(0, 1));
      addr = 3'($urandom_range(0, 7));
      data = 6'($urandom);
      if ($urandom_range(0, 3) == 0) bright = 4'($urandom);
      step();
    end
    wr = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
